// File: rtl/time_set_controller_pkg.sv
// time_set_controller_pkg: shared state encodings, field widths and wrap helper
package time_set_controller_pkg;

    localparam int MODE_W = 2;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    typedef enum logic [MODE_W-1:0] {
        ST_STOPPED = 2'b00,
        ST_SET_H   = 2'b01,
        ST_SET_M   = 2'b10,
        ST_RUN     = 2'b11
    } state_t;

    // Compare against the limit before incrementing; values never exceed max.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// time_set_controller_if: button/tick inputs and time/mode/blink outputs
interface time_set_controller_if;
    import time_set_controller_pkg::*;

    logic              db_set;
    logic              db_increment;
    logic              db_start;
    logic              tick_1hz;
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  minutes;
    logic [SEC_W-1:0]  seconds;
    logic [MODE_W-1:0] mode;
    logic              blink_h;
    logic              blink_m;

    modport master (
        output db_set, db_increment, db_start, tick_1hz,
        input  hours, minutes, seconds, mode, blink_h, blink_m
    );

    modport slave (
        input  db_set, db_increment, db_start, tick_1hz,
        output hours, minutes, seconds, mode, blink_h, blink_m
    );
endinterface

// File: rtl/time_set_controller_rising_edge_pulse.sv
// rising_edge_pulse: one-clock pulse per low-to-high transition of a level
module rising_edge_pulse (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);
    logic level_q;

    // History resets high so a button held through reset needs a fresh press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) level_q <= 1'b1;
        else       level_q <= level;
    end

    assign pulse = level & ~level_q;
endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: set-time FSM, cascaded HH:MM:SS counters and blink phase
module time_set_controller
    import time_set_controller_pkg::*;
#(
    parameter logic [HOUR_W-1:0] HOURS_MAX   = 5'd23,
    parameter logic [MIN_W-1:0]  MINUTES_MAX = 6'd59,
    parameter logic [SEC_W-1:0]  SECONDS_MAX = 6'd59
) (
    input  logic                  clock,
    input  logic                  reset,
    time_set_controller_if.slave  bus
);
    state_t            state, state_n;
    logic [HOUR_W-1:0] hours_q, hours_n;
    logic [MIN_W-1:0]  minutes_q, minutes_n;
    logic [SEC_W-1:0]  seconds_q, seconds_n;
    logic              phase_q, phase_n;
    logic              blink_h_q, blink_m_q;
    logic              p_set, p_inc, p_start;

    rising_edge_pulse u_set   (.clock(clock), .reset(reset), .level(bus.db_set),       .pulse(p_set));
    rising_edge_pulse u_inc   (.clock(clock), .reset(reset), .level(bus.db_increment), .pulse(p_inc));
    rising_edge_pulse u_start (.clock(clock), .reset(reset), .level(bus.db_start),     .pulse(p_start));

    // Registered state, time fields, blink phase and blink outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_STOPPED;
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            phase_q   <= 1'b0;
            blink_h_q <= 1'b0;
            blink_m_q <= 1'b0;
        end else begin
            state     <= state_n;
            hours_q   <= hours_n;
            minutes_q <= minutes_n;
            seconds_q <= seconds_n;
            phase_q   <= phase_n;
            blink_h_q <= (state_n == ST_SET_H) & phase_n;
            blink_m_q <= (state_n == ST_SET_M) & phase_n;
        end
    end

    // Next state and data; start beats set beats increment, ticks only count in RUN.
    always_comb begin
        state_n   = state;
        hours_n   = hours_q;
        minutes_n = minutes_q;
        seconds_n = seconds_q;
        phase_n   = phase_q;
        case (state)
            ST_STOPPED: begin
                if (p_start) state_n = ST_RUN;
                else if (p_set) begin
                    state_n = ST_SET_H;
                    phase_n = 1'b0;
                end
            end
            ST_RUN: begin
                if (p_start) state_n = ST_STOPPED;
                else if (p_set) begin
                    state_n   = ST_SET_H;
                    seconds_n = '0;
                    phase_n   = 1'b0;
                end else if (bus.tick_1hz) begin
                    seconds_n = wrap_inc(seconds_q, SECONDS_MAX);
                    if (seconds_q == SECONDS_MAX) begin
                        minutes_n = wrap_inc(minutes_q, MINUTES_MAX);
                        if (minutes_q == MINUTES_MAX)
                            hours_n = HOUR_W'(wrap_inc({1'b0, hours_q}, {1'b0, HOURS_MAX}));
                    end
                end
            end
            ST_SET_H: begin
                if (p_start) state_n = ST_RUN;
                else if (p_set) begin
                    state_n = ST_SET_M;
                    phase_n = 1'b0;
                end else if (p_inc) begin
                    hours_n = HOUR_W'(wrap_inc({1'b0, hours_q}, {1'b0, HOURS_MAX}));
                    phase_n = 1'b0;
                end else if (bus.tick_1hz) phase_n = ~phase_q;
            end
            default: begin
                if (p_start) state_n = ST_RUN;
                else if (p_set) begin
                    state_n = ST_SET_H;
                    phase_n = 1'b0;
                end else if (p_inc) begin
                    minutes_n = wrap_inc(minutes_q, MINUTES_MAX);
                    phase_n   = 1'b0;
                end else if (bus.tick_1hz) phase_n = ~phase_q;
            end
        endcase
    end

    assign bus.hours   = hours_q;
    assign bus.minutes = minutes_q;
    assign bus.seconds = seconds_q;
    assign bus.mode    = state;
    assign bus.blink_h = blink_h_q;
    assign bus.blink_m = blink_m_q;
endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: directed checks of the set-time controller
module tb_time_set_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    time_set_controller_if bus ();

    time_set_controller dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic s, input logic i, input logic st, input logic t);
        bus.db_set = s; bus.db_increment = i; bus.db_start = st; bus.tick_1hz = t;
        cyc();
        bus.db_set = 0; bus.db_increment = 0; bus.db_start = 0; bus.tick_1hz = 0;
        cyc();
    endtask

    task automatic tick();
        bus.tick_1hz = 1;
        cyc();
        bus.tick_1hz = 0;
    endtask

    task automatic test_reset();
        bus.db_set = 0; bus.db_increment = 0; bus.db_start = 1; bus.tick_1hz = 0;
        reset = 1;
        repeat (3) cyc();
        compared++;
        if ({bus.hours, bus.minutes, bus.seconds, bus.mode, bus.blink_h, bus.blink_m} !== 21'd0) begin
            mismatched++;
            $display("FAIL reset_values: got %0d:%0d:%0d mode=%0d bh=%0b bm=%0b want all 0",
                     bus.hours, bus.minutes, bus.seconds, bus.mode, bus.blink_h, bus.blink_m);
        end
        reset = 0;
        repeat (3) cyc();
        compared++;
        if (bus.mode !== 2'd0) begin
            mismatched++;
            $display("FAIL held_start_no_pulse: mode=%0d want 0", bus.mode);
        end
        bus.db_start = 0;
        cyc();
        bus.db_start = 1;
        cyc();
        compared++;
        if (bus.mode !== 2'd3) begin
            mismatched++;
            $display("FAIL start_one_cycle: mode=%0d want 3", bus.mode);
        end
        repeat (3) cyc();
        compared++;
        if (bus.mode !== 2'd3) begin
            mismatched++;
            $display("FAIL start_hold_no_repeat: mode=%0d want 3", bus.mode);
        end
        bus.db_start = 0;
        cyc();
        tick();
        compared++;
        if (bus.seconds !== 6'd1) begin
            mismatched++;
            $display("FAIL run_tick: seconds=%0d want 1", bus.seconds);
        end
        press(0, 0, 1, 0);
        tick();
        compared++;
        if (bus.mode !== 2'd0 || bus.seconds !== 6'd1) begin
            mismatched++;
            $display("FAIL pause_hold: mode=%0d seconds=%0d want 0/1", bus.mode, bus.seconds);
        end
    endtask

    task automatic test_hour_set();
        int h;
        press(1, 0, 0, 0);
        compared++;
        if (bus.mode !== 2'd1 || bus.blink_h !== 1'b0) begin
            mismatched++;
            $display("FAIL enter_set_h: mode=%0d blink_h=%0b want 1/0", bus.mode, bus.blink_h);
        end
        for (int i = 1; i <= 24; i++) begin
            tick();
            compared++;
            if (bus.blink_h !== 1'b1) begin
                mismatched++;
                $display("FAIL blink_h_toggle_%0d: blink_h=%0b want 1", i, bus.blink_h);
            end
            press(0, 1, 0, 0);
            h = i % 24;
            compared++;
            if (bus.hours !== 5'(h) || bus.blink_h !== 1'b0) begin
                mismatched++;
                $display("FAIL hour_inc_%0d: hours=%0d blink_h=%0b want %0d/0", i, bus.hours, bus.blink_h, h);
            end
        end
        repeat (23) press(0, 1, 0, 0);
        compared++;
        if (bus.hours !== 5'd23) begin
            mismatched++;
            $display("FAIL hours_to_23: hours=%0d want 23", bus.hours);
        end
    endtask

    task automatic test_minute_set();
        press(1, 0, 0, 0);
        compared++;
        if (bus.mode !== 2'd2 || bus.blink_m !== 1'b0 || bus.blink_h !== 1'b0) begin
            mismatched++;
            $display("FAIL enter_set_m: mode=%0d bm=%0b bh=%0b want 2/0/0", bus.mode, bus.blink_m, bus.blink_h);
        end
        repeat (59) press(0, 1, 0, 0);
        compared++;
        if (bus.minutes !== 6'd59) begin
            mismatched++;
            $display("FAIL minutes_to_59: minutes=%0d want 59", bus.minutes);
        end
        press(0, 1, 0, 0);
        compared++;
        if (bus.minutes !== 6'd0 || bus.hours !== 5'd23) begin
            mismatched++;
            $display("FAIL minute_wrap_no_carry: %0d:%0d want 23:0", bus.hours, bus.minutes);
        end
        repeat (59) press(0, 1, 0, 0);
    endtask

    task automatic test_rollover();
        press(0, 0, 1, 1);
        compared++;
        if (bus.mode !== 2'd3 || bus.seconds !== 6'd1) begin
            mismatched++;
            $display("FAIL start_tick_ignored: mode=%0d seconds=%0d want 3/1", bus.mode, bus.seconds);
        end
        repeat (57) tick();
        compared++;
        if (bus.hours !== 5'd23 || bus.minutes !== 6'd59 || bus.seconds !== 6'd58) begin
            mismatched++;
            $display("FAIL reach_235958: %0d:%0d:%0d want 23:59:58", bus.hours, bus.minutes, bus.seconds);
        end
        tick();
        compared++;
        if (bus.hours !== 5'd23 || bus.minutes !== 6'd59 || bus.seconds !== 6'd59) begin
            mismatched++;
            $display("FAIL reach_235959: %0d:%0d:%0d want 23:59:59", bus.hours, bus.minutes, bus.seconds);
        end
        tick();
        compared++;
        if (bus.hours !== 5'd0 || bus.minutes !== 6'd0 || bus.seconds !== 6'd0) begin
            mismatched++;
            $display("FAIL day_wrap: %0d:%0d:%0d want 0:0:0", bus.hours, bus.minutes, bus.seconds);
        end
    endtask

    task automatic test_priority();
        press(0, 1, 0, 0);
        compared++;
        if (bus.mode !== 2'd3 || bus.hours !== 5'd0 || bus.minutes !== 6'd0) begin
            mismatched++;
            $display("FAIL run_inc_ignored: mode=%0d %0d:%0d want 3 0:0", bus.mode, bus.hours, bus.minutes);
        end
        repeat (59) tick();
        press(1, 0, 0, 1);
        compared++;
        if (bus.mode !== 2'd1 || bus.seconds !== 6'd0 || bus.minutes !== 6'd0 || bus.hours !== 5'd0) begin
            mismatched++;
            $display("FAIL set_tick_dropped: mode=%0d %0d:%0d:%0d want 1 0:0:0",
                     bus.mode, bus.hours, bus.minutes, bus.seconds);
        end
        press(1, 1, 0, 0);
        compared++;
        if (bus.mode !== 2'd2 || bus.hours !== 5'd0) begin
            mismatched++;
            $display("FAIL set_beats_inc: mode=%0d hours=%0d want 2/0", bus.mode, bus.hours);
        end
        press(1, 0, 0, 0);
        press(1, 0, 1, 0);
        compared++;
        if (bus.mode !== 2'd3) begin
            mismatched++;
            $display("FAIL start_beats_set: mode=%0d want 3", bus.mode);
        end
    endtask

    task automatic test_reset_mid();
        repeat (5) tick();
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        tick();
        compared++;
        if (bus.mode !== 2'd2 || bus.blink_m !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset_blink_m: mode=%0d blink_m=%0b want 2/1", bus.mode, bus.blink_m);
        end
        #2 reset = 1;
        #1;
        compared++;
        if ({bus.hours, bus.minutes, bus.seconds, bus.mode, bus.blink_h, bus.blink_m} !== 21'd0) begin
            mismatched++;
            $display("FAIL async_reset: got %0d:%0d:%0d mode=%0d bh=%0b bm=%0b want all 0",
                     bus.hours, bus.minutes, bus.seconds, bus.mode, bus.blink_h, bus.blink_m);
        end
        cyc();
        reset = 0;
        repeat (2) cyc();
        compared++;
        if (bus.mode !== 2'd0 || bus.blink_m !== 1'b0) begin
            mismatched++;
            $display("FAIL post_reset_idle: mode=%0d blink_m=%0b want 0/0", bus.mode, bus.blink_m);
        end
    endtask

    initial begin
        test_reset();
        test_hour_set();
        test_minute_set();
        test_rollover();
        test_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
